stp_converter: RTL and testbench
================================

STP_CONVERTER -- requirements
Module: stp_converter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: data_in  input  8  serial byte stream (AES state bytes, column-major order).
REQ-004 SHALL have port: in_valid  input  1  data_in holds a valid byte this cycle.
REQ-005 SHALL have port: in_ready  output  1  block accepts data_in this cycle.
REQ-006 SHALL have port: d0, d1, d2, d3  output  8 each  assembled column word; d0 = first byte received, d3 = fourth.
REQ-007 SHALL have port: out_valid  output  1  d0..d3 hold a complete column.
REQ-008 SHALL have port: out_ready  input  1  downstream (parallel-to-serial stage) takes the column this cycle.
REQ-009 SHALL have port: last  output  1  held column is the fourth column of a 16-byte block; qualified by out_valid.
REQ-010 SHALL have port (STP_FLUSH_EN only): flush  input  1  discard partial column and realign block.

Function
REQ-011 SHALL accept a byte iff in_valid && in_ready on a rising edge.
REQ-012 SHALL track byte position with a 2-bit fill counter, states B0->B1->B2->B3->B0, advancing only on accept.
REQ-013 SHALL store accepted bytes in an assembly register; B0..B2 store to slots 0..2.
REQ-014 SHALL, on accept in B3, transfer slots 0..2 plus data_in into the output register (d0..d3) and set out_valid on the next cycle (latency 1 cycle from 4th byte accept).
REQ-015 SHALL keep d0..d3, last and out_valid stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid after out_valid && out_ready unless a new column loads in the same cycle.
REQ-017 SHALL drive in_ready = (fill != B3) || !out_valid || out_ready (combinational; no in_valid dependency).
REQ-018 SHALL sustain one byte per cycle with out_ready held high: out_valid every 4th cycle, no bubbles.
REQ-019 SHALL, on simultaneous output handshake and B3 accept, replace the output register with the new column and keep out_valid high.
REQ-020 SHALL count completed columns with a 2-bit column counter, incrementing on each column load and wrapping 3->0.
REQ-021 SHALL set last with the column load when the column counter equals 3 before increment.
REQ-022 SHALL ignore data_in when the byte is not accepted; the assembly register is unchanged.

Reset
REQ-023 SHALL, when rst is high at a rising edge, set fill = B0, column counter = 0, out_valid = 0, last = 0, d0..d3 = 8'h00, assembly slots = 8'h00, regardless of any other input.
REQ-024 SHALL drive in_ready = 1 in the first cycle after reset release.
REQ-025 SHALL discard any partial column and any held output column on reset mid-operation.

Configuration
REQ-026 SHALL, with macro STP_FLUSH_EN defined, provide flush: when flush is high (and rst low), set fill = B0 and column counter = 0, drop partial bytes, force in_ready = 0 that cycle, and leave the output register, out_valid and last unchanged.
REQ-027 SHALL, with flush and an output handshake in the same cycle, complete the handshake normally.
REQ-028 SHALL, without STP_FLUSH_EN, omit the flush port; behaviour equals flush tied 0.

Verification
REQ-029 SHALL cover: reset, then bytes 8'h32,8'h43,8'hF6,8'hA8 on 4 consecutive cycles, out_ready=1 -> next cycle out_valid=1, d0..d3=32,43,F6,A8, last=0.
REQ-030 SHALL cover: 16 consecutive bytes 00..0F, out_ready=1 -> four columns on cycles 4,8,12,16 after first accept; last=1 only with column 0C,0D,0E,0F.
REQ-031 SHALL cover: out_ready=0 after first column, 4 more bytes offered -> three accepted, in_ready=0 at 4th byte, column 1 held stable; raising out_ready -> column 1 then column 2 delivered in order, nothing lost.
REQ-032 SHALL cover: rst asserted after 2 bytes of a column -> out_valid=0, d0..d3=00; next 4 bytes AA,BB,CC,DD form the first column, last=0.
REQ-033 SHALL cover: out_valid && out_ready in same cycle as B3 accept -> out_valid stays 1, new column visible next cycle.
REQ-034 SHALL cover (STP_FLUSH_EN): flush after 3 bytes 11,22,33, then bytes 44,55,66,77 -> column 44,55,66,77, column counter restarted (4th subsequent column has last=1).

Source files
------------

// File: rtl/stp_converter.sv
// stp_converter: serial-to-parallel stage that assembles a byte stream
// (AES state bytes, column-major) into 32-bit columns d0..d3.
// A 2-bit fill counter tracks byte position inside the current column.
// A 2-bit column counter marks the fourth column of each 16-byte block with
// 'last'. The output register is a single-entry skid: a stalled column keeps
// the fourth byte of the next column off the bus through in_ready.
// Optional feature: define STP_FLUSH_EN to add a 'flush' input. Flush drops
// the partial column and realigns the block boundary.
module stp_converter (
    input  logic       clk,
    input  logic       rst,
`ifdef STP_FLUSH_EN
    input  logic       flush,
`endif
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] d0,
    output logic [7:0] d1,
    output logic [7:0] d2,
    output logic [7:0] d3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last
);

    // Fill-counter states: byte position of the next accepted byte
    localparam logic [1:0] B0 = 2'd0;
    localparam logic [1:0] B1 = 2'd1;
    localparam logic [1:0] B2 = 2'd2;
    localparam logic [1:0] B3 = 2'd3;

    logic [1:0] fill_r;
    logic [1:0] col_cnt_r;
    logic [7:0] slot0_r;
    logic [7:0] slot1_r;
    logic [7:0] slot2_r;
    logic [7:0] d0_r;
    logic [7:0] d1_r;
    logic [7:0] d2_r;
    logic [7:0] d3_r;
    logic       out_valid_r;
    logic       last_r;

    logic       flush_s;
    logic       in_ready_s;
    logic       accept_s;
    logic       load_s;
    logic       out_hs_s;

`ifdef STP_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Ready unless the 4th byte would have to overwrite a column still waiting downstream
    always_comb begin
        in_ready_s = 1'b1;
        if (flush_s) begin
            in_ready_s = 1'b0;
        end else if ((fill_r == B3) && out_valid_r && !out_ready) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign accept_s = in_valid && in_ready_s;
    assign load_s   = accept_s && (fill_r == B3);
    assign out_hs_s = out_valid_r && out_ready;

    // Byte-position tracking and assembly slots for bytes 0..2 of a column
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_r  <= B0;
            slot0_r <= 8'h00;
            slot1_r <= 8'h00;
            slot2_r <= 8'h00;
        end else if (flush_s) begin
            fill_r  <= B0;
            slot0_r <= 8'h00;
            slot1_r <= 8'h00;
            slot2_r <= 8'h00;
        end else if (accept_s) begin
            case (fill_r)
                B0: begin
                    slot0_r <= data_in;
                    fill_r  <= B1;
                end
                B1: begin
                    slot1_r <= data_in;
                    fill_r  <= B2;
                end
                B2: begin
                    slot2_r <= data_in;
                    fill_r  <= B3;
                end
                B3: begin
                    fill_r  <= B0;
                end
                default: begin
                    fill_r  <= B0;
                end
            endcase
        end else begin
            fill_r  <= fill_r;
            slot0_r <= slot0_r;
            slot1_r <= slot1_r;
            slot2_r <= slot2_r;
        end
    end

    // Column counter: position of the next loaded column within its 16-byte block
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_r <= 2'd0;
        end else if (flush_s) begin
            col_cnt_r <= 2'd0;
        end else if (load_s) begin
            col_cnt_r <= col_cnt_r + 2'd1;
        end else begin
            col_cnt_r <= col_cnt_r;
        end
    end

    // Output register: a new column wins over a same-cycle handshake so no bubble appears
    always_ff @(posedge clk) begin
        if (rst) begin
            d0_r        <= 8'h00;
            d1_r        <= 8'h00;
            d2_r        <= 8'h00;
            d3_r        <= 8'h00;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
        end else if (load_s) begin
            d0_r        <= slot0_r;
            d1_r        <= slot1_r;
            d2_r        <= slot2_r;
            d3_r        <= data_in;
            out_valid_r <= 1'b1;
            last_r      <= (col_cnt_r == 2'd3);
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            last_r      <= last_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign d0        = d0_r;
    assign d1        = d1_r;
    assign d2        = d2_r;
    assign d3        = d3_r;
    assign out_valid = out_valid_r;
    assign last      = last_r;

endmodule

// File: tb/tb_stp_converter.sv
// Randomized and directed bench for stp_converter against a byte-queue
// reference model. The model collects accepted bytes in a queue and publishes
// a column once four bytes are in it. Define STP_FLUSH_EN to also exercise flush.
module tb_stp_converter;

    logic       clk;
    logic       rst;
    logic       flush_v;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic       out_valid;
    logic       out_ready;
    logic       last;

`ifdef STP_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif

    stp_converter dut (
        .clk       (clk),
        .rst       (rst),
`ifdef STP_FLUSH_EN
        .flush     (flush_v),
`endif
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  part_q[$];
    int          col_idx;
    bit          exp_valid;
    logic [31:0] exp_col;
    bit          exp_last;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        part_q.delete();
        col_idx   = 0;
        exp_valid = 1'b0;
        exp_col   = 32'h0;
        exp_last  = 1'b0;
    endtask

    // One clock: drive inputs, check ready, advance model, check registered outputs
    task automatic step(input logic r, input logic iv, input logic [7:0] dat,
                        input logic ordy, input logic fl, output bit accepted);
        bit exp_rdy;
        bit hs;
        bit acc;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        data_in   = dat;
        out_ready = ordy;
        flush_v   = fl;
        #1;
        exp_rdy = !fl && !((part_q.size() == 3) && exp_valid && !ordy);
        if (!r) check_val("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        hs  = exp_valid && ordy;
        acc = iv && exp_rdy && !r;
        accepted = acc;
        if (r) begin
            model_reset();
        end else if (fl) begin
            part_q.delete();
            col_idx = 0;
            if (hs) exp_valid = 1'b0;
        end else if (acc && part_q.size() == 3) begin
            exp_col   = {part_q[0], part_q[1], part_q[2], dat};
            exp_valid = 1'b1;
            exp_last  = ((col_idx % 4) == 3);
            col_idx++;
            part_q.delete();
        end else begin
            if (acc) part_q.push_back(dat);
            if (hs) exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        check_val("column", {d0, d1, d2, d3}, exp_col);
        if (exp_valid) check_val("last", {31'b0, last}, {31'b0, exp_last});
    endtask

    // Offer one byte until accepted, bounded
    task automatic send_byte(input logic [7:0] b, input logic ordy);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 16) begin
            step(1'b0, 1'b1, b, ordy, 1'b0, acc);
            tries++;
        end
        if (!acc) check_val("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, ordy, 1'b0, acc);
    endtask

    task automatic do_reset();
        bit acc;
        step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, acc);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        logic [7:0] col_a[4];
        rst = 1'b1; flush_v = 1'b0; data_in = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();

        // Reset state and first-column example
        do_reset();
        check_val("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check_val("reset_column", {d0, d1, d2, d3}, 32'h0);
        #1;
        check_val("reset_in_ready", {31'b0, in_ready}, 32'h1);
        col_a[0] = 8'h32; col_a[1] = 8'h43; col_a[2] = 8'hF6; col_a[3] = 8'hA8;
        for (int i = 0; i < 4; i++) send_byte(col_a[i], 1'b1);
        check_val("ex_column", {d0, d1, d2, d3}, 32'h3243F6A8);
        check_val("ex_last", {31'b0, last}, 32'h0);
        idle(2, 1'b1);

        // Full 16-byte block, streaming
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        check_val("blk_last_col", {d0, d1, d2, d3}, 32'h0C0D0E0F);
        check_val("blk_last", {31'b0, last}, 32'h1);
        idle(2, 1'b1);

        // Backpressure: column 1 held, 4th byte of column 2 stalled
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h20 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h23, 1'b0, 1'b0, acc);
        check_val("stall_hold", {d0, d1, d2, d3}, 32'h10111213);
        send_byte(8'h23, 1'b1);
        check_val("stall_col2", {d0, d1, d2, d3}, 32'h20212223);
        idle(2, 1'b1);

        // Reset mid-column
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        do_reset();
        check_val("midrst_column", {d0, d1, d2, d3}, 32'h0);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        check_val("midrst_new", {d0, d1, d2, d3}, 32'hAABBCCDD);
        idle(1, 1'b1);

        // Handshake coinciding with 4th-byte load
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i), 1'b0);
        send_byte(8'h53, 1'b1);
        check_val("coinc_valid", {31'b0, out_valid}, 32'h1);
        check_val("coinc_col", {d0, d1, d2, d3}, 32'h50515253);
        idle(2, 1'b1);

        // Flush realigns the block
        if (HAS_FLUSH) begin
            do_reset();
            send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
            step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, acc);
            for (int i = 0; i < 16; i++) begin
                send_byte(8'h44 + 8'(i * 17), 1'b1);
                if (i == 3) check_val("flush_col", {d0, d1, d2, d3}, 32'h44556677);
            end
            check_val("flush_last", {31'b0, last}, 32'h1);
            idle(2, 1'b1);
        end

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 3) != 0),
                 8'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 (HAS_FLUSH && $urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
